// File: rtl/hazard_pkg.sv
// Shared constants, object state encoding and lane mapping for the road hazard objects.
package hazard_pkg;

  localparam int unsigned NUM_LANES = 5;
  localparam logic [10:0] LANE_X [NUM_LANES] = '{11'd32, 11'd160, 11'd288, 11'd416, 11'd544};
  localparam logic [10:0] OBJ_W    = 11'd64;
  localparam logic [10:0] OBJ_H    = 11'd64;
  localparam logic [10:0] SCREEN_H = 11'd480;

  typedef enum logic {
    WAIT,
    FALL
  } hazard_state_t;

  // Folds a 3-bit random index onto the five lanes: 5,6,7 wrap to 0,1,2.
  function automatic logic [2:0] lane_of(input logic [2:0] idx);
    return (idx >= 3'd5) ? idx - 3'd5 : idx;
  endfunction

endpackage

// File: rtl/hazard_object.sv
// One falling road object: spawn timer, position, overlap test against the car and hit pulse.
module hazard_object
  import hazard_pkg::*;
#(
  parameter int unsigned SPAWN_FRAMES = 90
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        menuLive,
  input  logic [10:0] spawn_x,
  input  logic [10:0] step,
  input  logic [10:0] CarX,
  input  logic [10:0] CarY,
  input  logic [10:0] CarW,
  input  logic [10:0] CarH,
  output logic        spawn,
  output logic        hit,
  output logic        Live,
  output logic [10:0] ObjX,
  output logic [10:0] ObjY
);

  localparam logic [15:0] RELOAD = 16'(SPAWN_FRAMES);

  hazard_state_t state;
  logic [15:0]   timer;
  logic [10:0]   car_top;
  logic [11:0]   car_right;
  logic [11:0]   car_bottom;
  logic [11:0]   obj_right;
  logic [11:0]   obj_bottom;
  logic [11:0]   y_next;
  logic          overlap;

  always_comb begin
    // A car partly above the screen (negative Y wraps into bit 10) counts as Y = 0.
    car_top    = CarY[10] ? '0 : CarY;
    car_right  = {1'b0, CarX} + {1'b0, CarW};
    car_bottom = {1'b0, car_top} + {1'b0, CarH};
    obj_right  = {1'b0, ObjX} + {1'b0, OBJ_W};
    obj_bottom = {1'b0, ObjY} + {1'b0, OBJ_H};
    overlap    = ({1'b0, ObjX} < car_right) && ({1'b0, CarX} < obj_right) &&
                 ({1'b0, ObjY} < car_bottom) && ({1'b0, car_top} < obj_bottom);
    hit        = (state == FALL) && overlap;
    spawn      = (state == WAIT) && (timer == '0);
    y_next     = {1'b0, ObjY} + {1'b0, step};
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= WAIT;
      timer <= RELOAD;
      Live  <= 1'b0;
      ObjX  <= '0;
      ObjY  <= '0;
    end else if (!menuLive) begin
      case (state)
        WAIT: begin
          if (timer == '0) begin
            state <= FALL;
            Live  <= 1'b1;
            ObjX  <= spawn_x;
            ObjY  <= '0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        FALL: begin
          // A hit freezes Y for that frame; leaving the screen despawns without effect.
          if (hit || (y_next >= {1'b0, SCREEN_H})) begin
            state <= WAIT;
            timer <= RELOAD;
            Live  <= 1'b0;
          end else begin
            ObjY <= y_next[10:0];
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: rtl/road_hazards.sv
// Oil slick and NOS canister spawning, scrolling and car collision effects.
// The oil object, its counter and noShift exist only when ROAD_HAZARDS_OIL_EN is defined.
module road_hazards
  import hazard_pkg::*;
#(
  parameter int unsigned SCROLL_STEP = 4,
  parameter int unsigned OIL_FRAMES  = 60,
  parameter int unsigned SPAWN_OIL   = 90,
  parameter int unsigned SPAWN_NOS   = 240,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        menuLive,
  input  logic [10:0] CarX,
  input  logic [10:0] CarY,
  input  logic [10:0] CarW,
  input  logic [10:0] CarH,
  input  logic        nosLoadedIn,
  input  logic        nosActive,
  output logic        nosLoadedOut,
  output logic        noShift,
  output logic [10:0] OilX,
  output logic [10:0] OilY,
  output logic [10:0] NosX,
  output logic [10:0] NosY,
  output logic        OilLive,
  output logic        NosLive
);

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0] lfsr;
  logic [2:0]  lane_idx;
  logic [2:0]  nos_idx;
  logic [10:0] step;
  logic        nos_prev;
  logic        nos_hit;
  logic        nos_spawn;
  logic        unused_inputs;

  assign lane_idx      = lane_of(lfsr[2:0]);
  assign step          = nosActive ? 11'(2 * SCROLL_STEP) : 11'(SCROLL_STEP);
  assign unused_inputs = nosLoadedIn ^ nos_spawn;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= LFSR_SEED;
    end else if (!menuLive) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

`ifdef ROAD_HAZARDS_OIL_EN
  logic        oil_hit;
  logic        oil_spawn;
  logic [15:0] oil_cnt;

  hazard_object #(
    .SPAWN_FRAMES(SPAWN_OIL)
  ) u_oil (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .menuLive  (menuLive),
    .spawn_x   (LANE_X[lane_idx]),
    .step      (step),
    .CarX      (CarX),
    .CarY      (CarY),
    .CarW      (CarW),
    .CarH      (CarH),
    .spawn     (oil_spawn),
    .hit       (oil_hit),
    .Live      (OilLive),
    .ObjX      (OilX),
    .ObjY      (OilY)
  );

  // Both objects draw from the same LFSR value, so a simultaneous spawn shifts NOS two lanes over.
  assign nos_idx = (oil_spawn && nos_spawn) ? lane_of(lane_idx + 3'd2) : lane_idx;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      noShift <= 1'b0;
      oil_cnt <= '0;
    end else if (!menuLive) begin
      if (oil_hit) begin
        noShift <= 1'b1;
        oil_cnt <= 16'(OIL_FRAMES);
      end else if (noShift) begin
        oil_cnt <= oil_cnt - 16'd1;
        if (oil_cnt == 16'd1) noShift <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (OIL_FRAMES == 0) || (SPAWN_OIL == 0);
  assign nos_idx    = lane_idx;
  assign noShift    = 1'b0;
  assign OilLive    = 1'b0;
  assign OilX       = '0;
  assign OilY       = '0;
`endif

  hazard_object #(
    .SPAWN_FRAMES(SPAWN_NOS)
  ) u_nos (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .menuLive  (menuLive),
    .spawn_x   (LANE_X[nos_idx]),
    .step      (step),
    .CarX      (CarX),
    .CarY      (CarY),
    .CarW      (CarW),
    .CarH      (CarH),
    .spawn     (nos_spawn),
    .hit       (nos_hit),
    .Live      (NosLive),
    .ObjX      (NosX),
    .ObjY      (NosY)
  );

  // A fresh NOS burn always empties the charge, even if a canister is collected that frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      nosLoadedOut <= 1'b1;
      nos_prev     <= 1'b0;
    end else if (!menuLive) begin
      nos_prev <= nosActive;
      if (nosActive && !nos_prev)
        nosLoadedOut <= 1'b0;
      else if (nos_hit && !nosLoadedOut && !nosActive)
        nosLoadedOut <= 1'b1;
    end
  end

endmodule

// File: tb/tb_road_hazards.sv
// Directed bench for road_hazards: spawn timing, lanes, scrolling, oil/NOS effects, freeze, lane arbitration.
module tb_road_hazards;

  logic        frame_clk;
  logic        Reset;
  logic        menuLive;
  logic        menuLive2;
  logic [10:0] CarX, CarY, CarW, CarH;
  logic        nosLoadedIn, nosActive;

  logic        nosLoadedOut, noShift, OilLive, NosLive;
  logic [10:0] OilX, OilY, NosX, NosY;

  logic        d2_nosLoadedOut, d2_noShift, d2_OilLive, d2_NosLive;
  logic [10:0] d2_OilX, d2_OilY, d2_NosX, d2_NosY;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned u;
  logic [15:0] m_lfsr;
  logic [15:0] m2_lfsr;
  logic [2:0]  raw_idx;
  int          exp_x;
  int          exp_nos2_x;
  int          exp_oil2_x;

  road_hazards dut (
    .frame_clk(frame_clk), .Reset(Reset), .menuLive(menuLive),
    .CarX(CarX), .CarY(CarY), .CarW(CarW), .CarH(CarH),
    .nosLoadedIn(nosLoadedIn), .nosActive(nosActive),
    .nosLoadedOut(nosLoadedOut), .noShift(noShift),
    .OilX(OilX), .OilY(OilY), .NosX(NosX), .NosY(NosY),
    .OilLive(OilLive), .NosLive(NosLive)
  );

  road_hazards #(
    .SPAWN_OIL(10),
    .SPAWN_NOS(10),
    .LFSR_SEED(16'h1234)
  ) dut2 (
    .frame_clk(frame_clk), .Reset(Reset), .menuLive(menuLive2),
    .CarX(CarX), .CarY(CarY), .CarW(CarW), .CarH(CarH),
    .nosLoadedIn(nosLoadedIn), .nosActive(nosActive),
    .nosLoadedOut(d2_nosLoadedOut), .noShift(d2_noShift),
    .OilX(d2_OilX), .OilY(d2_OilY), .NosX(d2_NosX), .NosY(d2_NosY),
    .OilLive(d2_OilLive), .NosLive(d2_NosLive)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic fb;
    fb = s[0];
    s  = {1'b0, s[15:1]};
    if (fb) begin
      s[15] = ~s[15];
      s[13] = ~s[13];
      s[12] = ~s[12];
      s[10] = ~s[10];
    end
    return s;
  endfunction

  function automatic int lane_x_of(input logic [2:0] idx);
    return 32 + 128 * (int'(idx) % 5);
  endfunction

  task automatic tick();
    if (!menuLive) begin
      u++;
      m_lfsr = lfsr_adv(m_lfsr);
    end
    @(posedge frame_clk);
    #1;
  endtask

  task automatic run_to(input int unsigned target);
    for (int unsigned k = 0; k < 5000 && u < target; k++) tick();
    if (u != target) check("run_to", u, target);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    u           = 0;
    Reset       = 1'b1;
    menuLive    = 1'b0;
    menuLive2   = 1'b0;
    CarX        = 11'd0;
    CarW        = 11'd700;
    CarY        = 11'd419;
    CarH        = 11'd130;
    nosLoadedIn = 1'b1;
    nosActive   = 1'b0;
    m_lfsr      = 16'hACE1;
    m2_lfsr     = 16'h1234;
    for (int i = 0; i < 10; i++) m2_lfsr = lfsr_adv(m2_lfsr);
    raw_idx = m2_lfsr[2:0];
`ifdef ROAD_HAZARDS_OIL_EN
    exp_oil2_x = lane_x_of(raw_idx);
    exp_nos2_x = lane_x_of(3'((int'(raw_idx) % 5 + 2) % 5));
`else
    exp_oil2_x = 0;
    exp_nos2_x = lane_x_of(raw_idx);
`endif

    #12;
    check("rst_nosLoaded", nosLoadedOut, 1);
    check("rst_noShift", noShift, 0);
    check("rst_OilLive", OilLive, 0);
    check("rst_NosLive", NosLive, 0);
    check("rst_OilX", OilX, 0);
    check("rst_OilY", OilY, 0);
    check("rst_NosX", NosX, 0);
    check("rst_NosY", NosY, 0);
    Reset = 1'b0;

    run_to(10);
    check("d2_NosLive_pre", d2_NosLive, 0);
    run_to(11);
    check("d2_NosLive", d2_NosLive, 1);
    check("d2_NosX", d2_NosX, exp_nos2_x);
    check("d2_OilX", d2_OilX, exp_oil2_x);

    run_to(90);
    check("OilLive_f90", OilLive, 0);
    check("NosLive_f90", NosLive, 0);
    raw_idx = m_lfsr[2:0];
    exp_x = lane_x_of(raw_idx);
    run_to(91);
`ifdef ROAD_HAZARDS_OIL_EN
    check("OilLive_f91", OilLive, 1);
    check("OilX_f91", OilX, exp_x);
    check("OilY_f91", OilY, 0);
`else
    check("OilLive_tied", OilLive, 0);
    check("OilX_tied", OilX, 0);
`endif

    run_to(100);
    nosActive = 1'b1;
    run_to(101);
    check("nos_burn_clear", nosLoadedOut, 0);
`ifdef ROAD_HAZARDS_OIL_EN
    check("OilY_fast1", OilY, 44);
`endif
    run_to(102);
`ifdef ROAD_HAZARDS_OIL_EN
    check("OilY_fast2", OilY, 52);
`endif
    nosActive = 1'b0;
    run_to(103);
`ifdef ROAD_HAZARDS_OIL_EN
    check("OilY_slow", OilY, 56);
`endif

    run_to(110);
    menuLive = 1'b1;
    repeat (20) tick();
`ifdef ROAD_HAZARDS_OIL_EN
    check("frz_OilY", OilY, 84);
    check("frz_OilLive", OilLive, 1);
`endif
    check("frz_nosLoaded", nosLoadedOut, 0);
    check("frz_NosLive", NosLive, 0);
    check("frz_noShift", noShift, 0);
    menuLive = 1'b0;
    run_to(111);
`ifdef ROAD_HAZARDS_OIL_EN
    check("OilY_resume", OilY, 88);
`endif

    run_to(178);
`ifdef ROAD_HAZARDS_OIL_EN
    check("OilY_f178", OilY, 356);
    check("noShift_f178", noShift, 0);
`endif
    run_to(179);
`ifdef ROAD_HAZARDS_OIL_EN
    check("noShift_hit", noShift, 1);
    check("OilLive_hit", OilLive, 0);
    run_to(238);
    check("noShift_f238", noShift, 1);
    run_to(239);
    check("noShift_f239", noShift, 0);
`else
    check("noShift_tied", noShift, 0);
`endif

    run_to(240);
    check("NosLive_f240", NosLive, 0);
    raw_idx = m_lfsr[2:0];
    exp_x = lane_x_of(raw_idx);
    run_to(241);
    check("NosLive_f241", NosLive, 1);
    check("NosX_f241", NosX, exp_x);
    check("NosY_f241", NosY, 0);

    run_to(330);
    check("NosY_f330", NosY, 356);
    check("nosLoaded_f330", nosLoadedOut, 0);
    run_to(331);
    check("nos_pickup", nosLoadedOut, 1);
    check("NosLive_pickup", NosLive, 0);

    run_to(661);
    check("NosLive_f661", NosLive, 1);
    check("NosY_f661", NosY, 356);
    nosActive = 1'b1;
    run_to(662);
    check("nos_clear_wins", nosLoadedOut, 0);
    check("NosLive_f662", NosLive, 0);
    nosActive = 1'b0;
    CarY = 11'd600;

    run_to(1022);
    check("NosY_f1022", NosY, 476);
    check("NosLive_f1022", NosLive, 1);
    run_to(1023);
    check("NosLive_despawn", NosLive, 0);
    check("nosLoaded_noeff", nosLoadedOut, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/road_hazards.md
# road_hazards

Spawns, scrolls and collides the two road pickups the player car reacts to: an oil slick and a nitro (NOS) canister. Consumes the car's bounding box and NOS handshake outputs, and produces the `noShift` and `nosLoadedOut` inputs the car module expects. Also exports object positions to the sprite/colour mapper. Runs on the frame clock alongside the car block.

## Interface
Parameters:
- `SCROLL_STEP`, 4: pixels per frame an object falls; doubled while `nosActive`.
- `OIL_FRAMES`, 60: frames `noShift` stays asserted after an oil hit.
- `SPAWN_OIL`, 90: frames between oil despawn and next oil spawn.
- `SPAWN_NOS`, 240: frames between NOS despawn and next NOS spawn.
- `LFSR_SEED`, 16'hACE1: reset value of the lane-select LFSR; must be non-zero.

Ports:
- `frame_clk` in 1: frame clock; the only clock.
- `Reset` in 1: asynchronous, active-high reset.
- `menuLive` in 1: when high, all state holds.
- `CarX`, `CarY`, `CarW`, `CarH` in 11 each: car bounding box, top-left plus size.
- `nosLoadedIn` in 1: the car's NOS-available flag; informational only.
- `nosActive` in 1: the car is burning NOS.
- `nosLoadedOut` out 1: a NOS charge is available to the car.
- `noShift` out 1: the car is on oil; lane changes are blocked.
- `OilX`, `OilY`, `NosX`, `NosY` out 11 each: top-left of each object.
- `OilLive`, `NosLive` out 1 each: the object is on screen.

## Operation
- Lanes: five lanes with left X of 32, 160, 288, 416 and 544. Objects are 64×64.
- LFSR: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances once per unfrozen frame.
  - Lane index is `lfsr[2:0]`; values 5, 6 and 7 map to lanes 0, 1 and 2.
- Per-object FSM:
  - WAIT: spawn timer counts down. When it reaches 0, the object loads `X` = lane, `Y` = 0 and moves to FALL.
  - FALL: `Y += step` each frame, where `step` is `SCROLL_STEP`, or `2*SCROLL_STEP` while `nosActive`.
    - Exits on a hit: returns to WAIT, reloads the timer and clears Live.
    - Exits when `Y >= 480` after the update: same as a hit, but with no effect applied.
  - `Live` is high only in FALL.
- Same-frame spawn in the same lane: NOS takes lane `(idx+2) mod 5`.
- Overlap test (combinational, on registered values):
  - Hit when `objX < CarX+CarW`, `CarX < objX+64`, `objY < CarY+CarH` and `CarY < objY+64`.
  - All sums are 12-bit unsigned.
  - If `CarY[10]` is set, `CarY` is treated as 0.
- Oil hit: `noShift` is set and the counter is loaded with `OIL_FRAMES`.
  - The counter decrements each unfrozen frame; `noShift` clears on the edge where it reaches 0.
  - A re-hit while active reloads the counter.
- NOS hit:
  - Sets `nosLoadedOut` only if `nosLoadedOut` is 0 and `nosActive` is 0.
  - Otherwise the canister is still consumed but has no effect.
- NOS consume: a rising edge of `nosActive` (registered previous value) clears `nosLoadedOut`.
  - If a pickup and a rising edge occur in the same frame, the clear wins.
- `menuLive` high: FSMs, timers, LFSR, oil counter and the edge register all hold; outputs stay stable.

## Timing
- Reset values:
  - `nosLoadedOut` = 1 (this matches the car's reset `nosLoadedIn` = 1).
  - `noShift` = 0; both Live = 0; all X/Y = 0.
  - FSMs in WAIT, with timers loaded with `SPAWN_OIL` / `SPAWN_NOS`.
  - LFSR = `LFSR_SEED`.
- All outputs are registered.
- Latency:
  - Overlap present at edge N → `noShift` / `nosLoadedOut` / Live update at edge N+1.
  - The first spawn occurs `SPAWN_*+1` unfrozen frames after reset release.
- Position updates and hit tests in the same frame: the hit test uses pre-update positions; a hit suppresses that frame's Y update.
- Reset mid-FALL: the object vanishes immediately (asynchronous).

## Configuration
- `ROAD_HAZARDS_OIL_EN` defined: the oil object, oil counter and `noShift` logic are compiled in.
- Undefined:
  - `noShift` is tied 0; `OilLive`, `OilX`, `OilY` are tied 0.
  - The LFSR and NOS path are unchanged, including the lane-collision rule (NOS always uses the raw lane index).

## Structure
- `hazard_pkg` holds:
  - the lane X constant array, `OBJ_W`/`OBJ_H` = 64 and `SCREEN_H` = 480;
  - the `hazard_state_t` enum {`WAIT`, `FALL`};
  - the `lane_of(logic [2:0])` function.
- Sub-module `hazard_object`: one falling object (FSM, spawn timer, X/Y, overlap compare, hit pulse output). It is instanced once for NOS and, under the macro, once for oil.
- The top level holds the LFSR, lane arbitration, oil counter and NOS flag.

## Test plan
- Reset release with `menuLive`=0, car at (288,419,64,130) → `NosLive`, `OilLive` stay 0 for 90 frames; `OilLive` rises on frame 91 at a lane X in {32,160,288,416,544}, `OilY`=0.
- Oil falls in lane 288 onto the stationary car → one frame after overlap, `noShift`=1 and `OilLive`=0; `noShift` returns to 0 exactly 60 frames later.
- NOS pickup with `nosLoadedOut`=0 → `nosLoadedOut`=1 next edge; raise `nosActive` → `nosLoadedOut`=0 next edge; a pickup in that same frame still leaves it 0.
- `nosActive`=1 during FALL → `Y` increments by 8 per frame; with `nosActive`=0, by 4; car moved out of the lane → object despawns after crossing Y≥480 with no effect.
- `menuLive`=1 for 20 frames mid-FALL → all outputs constant; counting resumes exactly where it stopped.
- Force the same lane index for both spawns → NOS X is two lanes to the right, mod 5 (e.g. oil 416, NOS 32).
